fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arb_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_rr_picker.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
// Used by fifo_wr_arbiter and rr_picker.
package fifo_wr_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int STAT_W = 16;
   localparam int CNT_W  = 8;

   // Index width for n requesters; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// searching upward with wrap.
module rr_picker
   import fifo_wr_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IW      = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IW-1:0]      rr_ptr,
   output logic [IW-1:0]      pick_id,
   output logic               pick_valid
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [IW:0]          sum;

   always_comb begin
      pick_id    = '0;
      pick_valid = 1'b0;
      sum        = '0;
      // Rotate so bit 0 is rr_ptr; lowest set bit is the winner.
      dbl = {req_valid, req_valid} >> rr_ptr;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (dbl[j]) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(j);
            if (sum >= (IW+1)'(NUM_REQ))
               sum = sum - (IW+1)'(NUM_REQ);
            pick_id    = sum[IW-1:0];
            pick_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the async FIFO write port (w_clk domain).
// Optional per-requester beat counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_W    = 8,
   parameter  int MAX_BURST = 8,
   localparam int IW        = idx_w(NUM_REQ)
) (
   input  logic                      w_clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      full,
   input  logic                      almost_full,
   output logic [DATA_W-1:0]         fifo_wdata,
   output logic                      fifo_wen,
   output logic                      fifo_wr_valid,
   output logic [IW-1:0]             grant_id,
   output logic                      busy,
   input  logic [IW-1:0]             stat_sel,
   output logic [STAT_W-1:0]         stat_count
);

   arb_state_t                       state, state_nxt;
   logic [IW-1:0]                    rr_ptr, pick_id;
   logic                             pick_valid;
   logic [CNT_W-1:0]                 beat_cnt;
   logic [NUM_REQ-1:0][DATA_W-1:0]   data_arr;
   logic [DATA_W-1:0]                acc_data;
   logic                             slot_ok, accept, burst_end;

   assign data_arr = req_data;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_valid  (req_valid),
      .rr_ptr     (rr_ptr),
      .pick_id    (pick_id),
      .pick_valid (pick_valid)
   );

   // A beat sitting in the output register still needs a slot, so
   // almost_full blocks only while that register is occupied.
   assign slot_ok   = (state == BURST) && !full && !(almost_full && fifo_wr_valid);
   assign accept    = slot_ok && req_valid[grant_id];
   assign acc_data  = data_arr[grant_id];
   assign burst_end = accept && (req_last[grant_id] ||
                                 beat_cnt == CNT_W'(MAX_BURST - 1));

   always_comb begin
      req_ready = '0;
      if (slot_ok)
         req_ready[grant_id] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_valid) state_nxt = BURST;
         BURST:   if (burst_end)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge w_clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge w_clk) begin
      if (rst) begin
         grant_id <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         if (state == IDLE && pick_valid) begin
            grant_id <= pick_id;
            beat_cnt <= '0;
         end
         if (accept)
            beat_cnt <= beat_cnt + CNT_W'(1);
         if (burst_end)
            rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
      end
   end

   always_ff @(posedge w_clk) begin
      if (rst) begin
         fifo_wr_valid <= 1'b0;
         fifo_wdata    <= '0;
      end else begin
         fifo_wr_valid <= accept;
         fifo_wdata    <= accept ? acc_data : '0;
      end
   end

   assign fifo_wen = fifo_wr_valid;
   assign busy     = (state == BURST);

`ifdef FIFO_WR_ARB_STATS_EN
   logic [STAT_W-1:0] stat_cnt [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
      always_ff @(posedge w_clk) begin
         if (rst)
            stat_cnt[i] <= '0;
         else if (accept && grant_id == IW'(i) && stat_cnt[i] != '1)
            stat_cnt[i] <= stat_cnt[i] + STAT_W'(1);
      end
   end

   assign stat_count = ({1'b0, stat_sel} < (IW+1)'(NUM_REQ)) ? stat_cnt[stat_sel] : '0;
`else
   logic stats_unused;
   assign stats_unused = ^stat_sel;
   assign stat_count   = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: decode table plus scoreboarded
// multi-cycle sequences (bursts, round-robin, forced split, stalls, reset).
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 8;
   localparam int IW = 2;

   logic            w_clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_last, req_ready;
   logic [N*DW-1:0] req_data;
   logic            full, almost_full;
   logic [DW-1:0]   fifo_wdata;
   logic            fifo_wen, fifo_wr_valid, busy;
   logic [IW-1:0]   grant_id, stat_sel;
   logic [15:0]     stat_count;

   always #5 w_clk = ~w_clk;

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .w_clk         (w_clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .full          (full),
      .almost_full   (almost_full),
      .fifo_wdata    (fifo_wdata),
      .fifo_wen      (fifo_wen),
      .fifo_wr_valid (fifo_wr_valid),
      .grant_id      (grant_id),
      .busy          (busy),
      .stat_sel      (stat_sel),
      .stat_count    (stat_count)
   );

   typedef struct {
      logic [N-1:0] valid;
      logic [7:0]   data;
      logic         last;
      logic         full;
      logic         af;
      logic [N-1:0] ready;
      logic         busy;
      logic [1:0]   grant;
      logic         wv;
      logic [7:0]   wd;
   } vec_t;

   vec_t        tbl [12];
   int          n_cmp = 0, n_err = 0, cycn = 0;
   logic [8:0]  rq [N][$];
   logic [7:0]  exp_q [$];
   int          out_cyc [$];
   logic        out_busy [$];
   logic [N-1:0] acc, t_valid;
   logic [7:0]  t_data;
   logic        t_last, n_full, n_af;
   bit          drv_en, sb_en;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   // One clock: drive at posedge+1, observe and score at negedge.
   task automatic cyc();
      logic [8:0] tmp;
      @(posedge w_clk);
      #1;
      cycn++;
      for (int i = 0; i < N; i++) begin
         if (acc[i] && rq[i].size() > 0) tmp = rq[i].pop_front();
         if (drv_en) begin
            req_valid[i] = (rq[i].size() > 0);
            if (rq[i].size() > 0) {req_last[i], req_data[i*DW +: DW]} = rq[i][0];
            else                  {req_last[i], req_data[i*DW +: DW]} = '0;
         end else begin
            req_valid[i]         = t_valid[i];
            req_last[i]          = t_last;
            req_data[i*DW +: DW] = t_data;
         end
      end
      full        = n_full;
      almost_full = n_af;
      @(negedge w_clk);
      acc = req_valid & req_ready;
      if (sb_en && fifo_wr_valid) begin
         chk("sb_wen", 32'(fifo_wen), 32'd1);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: wrote %0h with nothing expected", fifo_wdata);
         end else begin
            chk("sb_wdata", 32'(fifo_wdata), 32'(exp_q.pop_front()));
            out_cyc.push_back(cycn);
            out_busy.push_back(busy);
         end
      end
   endtask

   task automatic put(input int id, input logic [7:0] d, input logic last);
      rq[id].push_back({last, d});
   endtask

   function automatic bit rq_empty();
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) rq[i].delete();
      exp_q.delete();
      out_cyc.delete();
      out_busy.delete();
      acc    = '0;
      n_full = 1'b0;
      n_af   = 1'b0;
      cyc();
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      int k = 0;
      while ((busy || fifo_wr_valid || !rq_empty() || exp_q.size() > 0) && k < 300) begin
         cyc();
         k++;
      end
      n_cmp++;
      if (k >= 300) begin
         n_err++;
         $display("FAIL %s_timeout: %0d beats still expected, busy=%0b", name, exp_q.size(), busy);
      end
      repeat (3) cyc();
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
      full = 1'b0; almost_full = 1'b0; stat_sel = '0;
      t_valid = '0; t_data = '0; t_last = 1'b0; drv_en = 1'b0; sb_en = 1'b0;

      // valid, data, last, full, af | ready, busy, grant, wv, wd
      tbl[0]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
      tbl[1]  = '{4'b0010, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
      tbl[2]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h00};
      tbl[3]  = '{4'b0101, 8'h00, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0, 8'h00};
      tbl[4]  = '{4'b0101, 8'h00, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h00};
      tbl[5]  = '{4'b0111, 8'hA1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h00};
      tbl[6]  = '{4'b0111, 8'hA2, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1, 8'hA1};
      tbl[7]  = '{4'b0111, 8'hA2, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h00};
      tbl[8]  = '{4'b0101, 8'hC1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 8'hA2};
      tbl[9]  = '{4'b0101, 8'hC1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 8'h00};
      tbl[10] = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 8'hC1};
      tbl[11] = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};

      // Reset state
      do_reset();
      chk("rst_wr_valid", 32'(fifo_wr_valid), 0);
      chk("rst_wen",      32'(fifo_wen), 0);
      chk("rst_wdata",    32'(fifo_wdata), 0);
      chk("rst_busy",     32'(busy), 0);
      chk("rst_grant",    32'(grant_id), 0);
      chk("rst_ready",    32'(req_ready), 0);
      chk("rst_stat",     32'(stat_count), 0);

      // Ready decode, lock, stalls and turnaround, one row per cycle
      for (int r = 0; r < 12; r++) begin
         t_valid = tbl[r].valid; t_data = tbl[r].data; t_last = tbl[r].last;
         n_full  = tbl[r].full;  n_af   = tbl[r].af;
         cyc();
         chk($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].ready));
         chk($sformatf("tbl%0d_busy", r),  32'(busy), 32'(tbl[r].busy));
         chk($sformatf("tbl%0d_wv", r),    32'(fifo_wr_valid), 32'(tbl[r].wv));
         chk($sformatf("tbl%0d_wd", r),    32'(fifo_wdata), 32'(tbl[r].wd));
         if (tbl[r].busy) chk($sformatf("tbl%0d_grant", r), 32'(grant_id), 32'(tbl[r].grant));
      end
      t_valid = '0;
      drv_en  = 1'b1;
      sb_en   = 1'b1;

      // 3-beat burst from requester 0: latency 2, back-to-back, then rr_ptr=1
      begin
         int start;
         do_reset();
         put(0, 8'h11, 1'b0); put(0, 8'h22, 1'b0); put(0, 8'h33, 1'b1);
         exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
         start = cycn + 1;
         drain("burst3");
         chk("burst3_count", 32'(out_cyc.size()), 3);
         if (out_cyc.size() == 3) begin
            chk("burst3_lat0", 32'(out_cyc[0] - start), 2);
            chk("burst3_lat1", 32'(out_cyc[1] - start), 3);
            chk("burst3_lat2", 32'(out_cyc[2] - start), 4);
            chk("burst3_busy_mid", 32'(out_busy[1]), 1);
            chk("burst3_busy_end", 32'(out_busy[2]), 0);
         end
         put(0, 8'h44, 1'b1); put(1, 8'h55, 1'b1);
         exp_q.push_back(8'h55); exp_q.push_back(8'h44);
         drain("rrptr1");
      end

      // All four requesters, single-beat bursts: 0,1,2,3,0,... every 2 cycles
      do_reset();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) begin
            put(i, 8'(i*16 + r), 1'b1);
            exp_q.push_back(8'(i*16 + r));
         end
      drain("rr4");
      chk("rr4_count", 32'(out_cyc.size()), 8);
      for (int k = 1; k < out_cyc.size(); k++)
         chk($sformatf("rr4_gap%0d", k), 32'(out_cyc[k] - out_cyc[k-1]), 2);

      // Forced split at MAX_BURST, requester 3 gets its turn in between
      do_reset();
      for (int n = 1; n <= 12; n++) put(2, 8'(32 + n), (n == 12));
      for (int n = 1; n <= 2; n++)  put(3, 8'(48 + n), (n == 2));
      for (int n = 1; n <= 8; n++)  exp_q.push_back(8'(32 + n));
      for (int n = 1; n <= 2; n++)  exp_q.push_back(8'(48 + n));
      for (int n = 9; n <= 12; n++) exp_q.push_back(8'(32 + n));
      drain("split");

      // almost_full with a beat in flight, then 5 cycles of full
      begin
         int k = 0;
         do_reset();
         n_af = 1'b1;
         for (int n = 1; n <= 6; n++) begin
            put(1, 8'(16 + n), (n == 6));
            exp_q.push_back(8'(16 + n));
         end
         while (!fifo_wr_valid && k < 20) begin cyc(); k++; end
         chk("af_seen_write", 32'(fifo_wr_valid), 1);
         chk("af_ready_low",  32'(req_ready), 0);
         n_af   = 1'b0;
         n_full = 1'b1;
         for (int c = 0; c < 5; c++) begin
            cyc();
            chk($sformatf("full%0d_wen", c),   32'(fifo_wen), 0);
            chk($sformatf("full%0d_ready", c), 32'(req_ready), 0);
            chk($sformatf("full%0d_busy", c),  32'(busy), 1);
            chk($sformatf("full%0d_grant", c), 32'(grant_id), 1);
         end
         n_full = 1'b0;
         drain("stall");
      end

      // Reset mid-burst after 2 of 4 accepts; requester 0 wins afterwards
      begin
         int k = 0, na = 0;
         do_reset();
         put(2, 8'h2A, 1'b1); exp_q.push_back(8'h2A);
         drain("pre_rst");
         for (int n = 1; n <= 4; n++) put(0, 8'(n), (n == 4));
         exp_q.push_back(8'h01);
         while (na < 2 && k < 20) begin
            cyc();
            if (acc[0]) na++;
            k++;
         end
         chk("mid_rst_accepts", 32'(na), 2);
         rst = 1'b1;
         for (int i = 0; i < N; i++) rq[i].delete();
         acc = '0;
         cyc();
         rst = 1'b0;
         chk("mid_rst_wr_valid", 32'(fifo_wr_valid), 0);
         chk("mid_rst_wen",      32'(fifo_wen), 0);
         chk("mid_rst_wdata",    32'(fifo_wdata), 0);
         chk("mid_rst_busy",     32'(busy), 0);
         chk("mid_rst_grant",    32'(grant_id), 0);
         chk("mid_rst_ready",    32'(req_ready), 0);
         chk("mid_rst_pending",  32'(exp_q.size()), 0);
         exp_q.delete();
         put(0, 8'hA0, 1'b1); put(3, 8'hA3, 1'b1);
         exp_q.push_back(8'hA0); exp_q.push_back(8'hA3);
         drain("post_rst");
      end

      // Statistics: 5 beats from requester 1
      do_reset();
      for (int n = 1; n <= 5; n++) begin
         put(1, 8'(96 + n), (n == 5));
         exp_q.push_back(8'(96 + n));
      end
      drain("stats");
      stat_sel = 2'd1;
      #1;
`ifdef FIFO_WR_ARB_STATS_EN
      chk("stat_req1", 32'(stat_count), 5);
`else
      chk("stat_req1", 32'(stat_count), 0);
`endif
      stat_sel = 2'd0;
      #1;
      chk("stat_req0", 32'(stat_count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
